// File: rtl/ahb_bus_arbiter_if.sv
// rtl/ahb_bus_arbiter_if.sv - AHB arbitration signal group shared by masters and the central arbiter
interface ahb_bus_arbiter_if;
  logic [15:0] hbusreq;
  logic [15:0] hlock;
  logic        hready;
  logic [1:0]  htrans;
  logic [1:0]  hresp;
  logic [15:0] hsplit;
  logic [15:0] hgrant;
  logic [3:0]  hmaster;
  logic        hmastlock;

  modport slave (
    input  hbusreq, hlock, hready, htrans, hresp, hsplit,
    output hgrant, hmaster, hmastlock
  );

  modport master (
    output hbusreq, hlock, hready, htrans, hresp, hsplit,
    input  hgrant, hmaster, hmastlock
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// rtl/ahb_bus_arbiter.sv - central AHB arbiter, round-robin by default, fixed priority with ARB_FIXED_PRIO_EN
// Honours locked sequences, burst protection and SPLIT masking; defaults to DEFAULT_MASTER when idle.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 16,
  parameter int DEFAULT_MASTER = 0
) (
  input logic           hclk,
  input logic           hrst,
  ahb_bus_arbiter_if.slave bus
);

  localparam logic [31:0] VALID32    = (32'h1 << NUM_MASTERS) - 32'h1;
  localparam logic [15:0] VALID_MASK = VALID32[15:0];
  localparam logic [3:0]  DEF_IDX    = 4'(DEFAULT_MASTER);
  localparam logic [15:0] DEF_GRANT  = 16'(32'h1 << DEFAULT_MASTER);

  logic [15:0] hgrant_q, hgrant_d;
  logic [3:0]  hmaster_q, hmaster_d;
  logic        hmastlock_q, hmastlock_d;
  logic [15:0] split_mask_q, split_mask_d;

  logic [3:0]  owner;
  logic [3:0]  winner;
  logic [3:0]  cand;
  logic        found;
  logic        lock_hold;
  logic        split_set;
  logic        forced;
  logic        rp;
  logic [15:0] eligible;

`ifndef ARB_FIXED_PRIO_EN
  localparam logic [3:0] RR_RESET = 4'((DEFAULT_MASTER + 1) % NUM_MASTERS);
  logic [3:0] rr_ptr_q, rr_ptr_d;
`endif

  always_comb begin
    owner = '0;
    for (int i = 0; i < 16; i++) begin
      if (hgrant_q[i]) owner = 4'(i);
    end

    lock_hold = bus.hlock[owner] & bus.hbusreq[owner];
    split_set = (bus.hresp == 2'b11) && !bus.hready;
    forced    = split_set && hgrant_q[hmaster_q];
    rp        = bus.hready && (bus.htrans == 2'b00 || bus.htrans == 2'b10) && !lock_hold;

    // The split master's mask bit only lands at this edge, so exclude it explicitly.
    eligible = bus.hbusreq & ~split_mask_q & VALID_MASK;
    if (forced) eligible[hmaster_q] = 1'b0;

    found  = 1'b0;
    winner = DEF_IDX;
    cand   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      cand = 4'(k);
`else
      cand = 4'((int'(rr_ptr_q) + k) % NUM_MASTERS);
`endif
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end

    hgrant_d = hgrant_q;
`ifndef ARB_FIXED_PRIO_EN
    rr_ptr_d = rr_ptr_q;
`endif
    if (rp || forced) begin
      hgrant_d = 16'(32'h1 << winner);
`ifndef ARB_FIXED_PRIO_EN
      if (found) rr_ptr_d = 4'((int'(winner) + 1) % NUM_MASTERS);
`endif
    end

    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    if (bus.hready) begin
      hmaster_d   = owner;
      hmastlock_d = bus.hlock[owner];
    end

    // A release pulse overrides a SPLIT arriving for the same master in the same cycle.
    split_mask_d = split_mask_q;
    if (split_set) split_mask_d[hmaster_q] = 1'b1;
    split_mask_d = split_mask_d & ~bus.hsplit & VALID_MASK;
  end

  always_ff @(posedge hclk) begin
    if (hrst) begin
      hgrant_q     <= DEF_GRANT;
      hmaster_q    <= DEF_IDX;
      hmastlock_q  <= 1'b0;
      split_mask_q <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr_q     <= RR_RESET;
`endif
    end else begin
      hgrant_q     <= hgrant_d;
      hmaster_q    <= hmaster_d;
      hmastlock_q  <= hmastlock_d;
      split_mask_q <= split_mask_d;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

  assign bus.hgrant    = hgrant_q;
  assign bus.hmaster   = hmaster_q;
  assign bus.hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb/tb_ahb_bus_arbiter.sv - vector-table bench for ahb_bus_arbiter (round-robin build)
module tb_ahb_bus_arbiter;

  logic hclk = 1'b0;
  logic hrst;
  int   errors = 0;
  int   checks = 0;

  ahb_bus_arbiter_if bus ();

  ahb_bus_arbiter #(.NUM_MASTERS(16), .DEFAULT_MASTER(0)) dut (
    .hclk (hclk),
    .hrst (hrst),
    .bus  (bus)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic [15:0] req;
    logic [15:0] lock;
    logic        rdy;
    logic [1:0]  trans;
    logic [1:0]  resp;
    logic [15:0] split;
    logic [15:0] eg;
    logic [3:0]  em;
    logic        el;
  } vec_t;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [1:0] OK = 2'b00, SPL = 2'b11;

  vec_t vecs[27];

  function automatic vec_t mk(logic [15:0] req, logic [15:0] lock, logic rdy, logic [1:0] trans,
                              logic [1:0] resp, logic [15:0] split, logic [15:0] eg, logic [3:0] em,
                              logic el);
    vec_t v;
    v.req = req; v.lock = lock; v.rdy = rdy; v.trans = trans; v.resp = resp; v.split = split;
    v.eg = eg; v.em = em; v.el = el;
    return v;
  endfunction

  task automatic drive(logic [15:0] req, logic [15:0] lock, logic rdy, logic [1:0] trans,
                       logic [1:0] resp, logic [15:0] split);
    bus.hbusreq = req;
    bus.hlock   = lock;
    bus.hready  = rdy;
    bus.htrans  = trans;
    bus.hresp   = resp;
    bus.hsplit  = split;
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic check(string name, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, got, exp);
    end
  endtask

  task automatic check_outs(string tag, logic [15:0] eg, logic [3:0] em, logic el);
    check({tag, ".hgrant"}, bus.hgrant, eg);
    check({tag, ".hmaster"}, {12'h0, bus.hmaster}, {12'h0, em});
    check({tag, ".hmastlock"}, {15'h0, bus.hmastlock}, {15'h0, el});
  endtask

  initial begin
    //                 req      lock     rdy  trans resp split    grant    mst  lk
    vecs[0]  = mk(16'h0000, 16'h0000, 1, IDLE, OK,  16'h0000, 16'h0001, 4'd0, 0);
    vecs[1]  = mk(16'h0000, 16'h0000, 1, IDLE, OK,  16'h0000, 16'h0001, 4'd0, 0);
    vecs[2]  = mk(16'h0006, 16'h0000, 1, IDLE, OK,  16'h0000, 16'h0002, 4'd0, 0);
    vecs[3]  = mk(16'h0006, 16'h0000, 1, NSEQ, OK,  16'h0000, 16'h0004, 4'd1, 0);
    vecs[4]  = mk(16'h0006, 16'h0000, 1, IDLE, OK,  16'h0000, 16'h0002, 4'd2, 0);
    vecs[5]  = mk(16'h0006, 16'h0000, 1, NSEQ, OK,  16'h0000, 16'h0004, 4'd1, 0);
    vecs[6]  = mk(16'h0008, 16'h0000, 1, IDLE, OK,  16'h0000, 16'h0008, 4'd2, 0);
    vecs[7]  = mk(16'h0008, 16'h0000, 1, NSEQ, OK,  16'h0000, 16'h0008, 4'd3, 0);
    vecs[8]  = mk(16'h0028, 16'h0000, 1, SEQ,  OK,  16'h0000, 16'h0008, 4'd3, 0);
    vecs[9]  = mk(16'h0028, 16'h0000, 1, BUSY, OK,  16'h0000, 16'h0008, 4'd3, 0);
    vecs[10] = mk(16'h0028, 16'h0000, 1, SEQ,  OK,  16'h0000, 16'h0008, 4'd3, 0);
    vecs[11] = mk(16'h0028, 16'h0000, 1, IDLE, OK,  16'h0000, 16'h0020, 4'd3, 0);
    vecs[12] = mk(16'h0004, 16'h0004, 1, IDLE, OK,  16'h0000, 16'h0004, 4'd5, 0);
    vecs[13] = mk(16'h0084, 16'h0004, 1, IDLE, OK,  16'h0000, 16'h0004, 4'd2, 1);
    vecs[14] = mk(16'h0084, 16'h0004, 1, NSEQ, OK,  16'h0000, 16'h0004, 4'd2, 1);
    vecs[15] = mk(16'h0084, 16'h0000, 1, IDLE, OK,  16'h0000, 16'h0080, 4'd2, 0);
    vecs[16] = mk(16'h0000, 16'h0000, 1, IDLE, OK,  16'h0000, 16'h0001, 4'd7, 0);
    vecs[17] = mk(16'h0010, 16'h0000, 1, IDLE, OK,  16'h0000, 16'h0010, 4'd0, 0);
    vecs[18] = mk(16'h0110, 16'h0000, 1, SEQ,  OK,  16'h0000, 16'h0010, 4'd4, 0);
    vecs[19] = mk(16'h0110, 16'h0000, 0, SEQ,  SPL, 16'h0000, 16'h0100, 4'd4, 0);
    vecs[20] = mk(16'h0110, 16'h0000, 1, IDLE, SPL, 16'h0000, 16'h0100, 4'd8, 0);
    vecs[21] = mk(16'h0010, 16'h0000, 1, IDLE, OK,  16'h0000, 16'h0001, 4'd8, 0);
    vecs[22] = mk(16'h0010, 16'h0000, 1, IDLE, OK,  16'h0010, 16'h0001, 4'd0, 0);
    vecs[23] = mk(16'h0010, 16'h0000, 1, IDLE, OK,  16'h0000, 16'h0010, 4'd0, 0);
    vecs[24] = mk(16'h0210, 16'h0000, 1, SEQ,  OK,  16'h0000, 16'h0010, 4'd4, 0);
    vecs[25] = mk(16'h0210, 16'h0000, 0, SEQ,  SPL, 16'h0000, 16'h0200, 4'd4, 0);
    vecs[26] = mk(16'h0200, 16'h0000, 1, SEQ,  OK,  16'h0000, 16'h0200, 4'd9, 0);

    drive(16'h0, 16'h0, 1'b1, IDLE, OK, 16'h0);
    hrst = 1'b1;
    step();
    step();
    hrst = 1'b0;
    check_outs("reset", 16'h0001, 4'd0, 1'b0);

    for (int i = 0; i < 27; i++) begin
      drive(vecs[i].req, vecs[i].lock, vecs[i].rdy, vecs[i].trans, vecs[i].resp, vecs[i].split);
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].eg, vecs[i].em, vecs[i].el);
    end

    // Reset in the middle of master 9's burst while master 4 is split-masked.
    drive(16'h0200, 16'h0000, 1'b1, SEQ, OK, 16'h0);
    hrst = 1'b1;
    step();
    hrst = 1'b0;
    check_outs("midrst", 16'h0001, 4'd0, 1'b0);
    drive(16'h0010, 16'h0000, 1'b1, IDLE, OK, 16'h0);
    step();
    check_outs("postrst_mask_clear", 16'h0010, 4'd0, 1'b0);

    // SPLIT and release on the same master in the same cycle: release wins.
    drive(16'h0010, 16'h0000, 1'b1, SEQ, OK, 16'h0);
    step();
    check_outs("own4", 16'h0010, 4'd4, 1'b0);
    drive(16'h0030, 16'h0000, 1'b0, SEQ, SPL, 16'h0010);
    step();
    check_outs("split_and_clear", 16'h0020, 4'd4, 1'b0);
    drive(16'h0010, 16'h0000, 1'b1, IDLE, OK, 16'h0);
    step();
    check_outs("clear_wins", 16'h0010, 4'd5, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
